// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl
// Purpose  : Sequences machine-mode trap entry and mret through the single
//            CSR-file write port. Arbitrates that port between pipeline CSR
//            instruction writes and its own multi-cycle updates. Tracks the
//            privilege mode and produces the PC redirect.
// Ports    :
//   clk, reset           - clock, synchronous active-high reset
//   trap_req/pc/cause/tval - commit-stage trap request and its payload
//   mret_req             - commit-stage mret request
//   pipe_csr_*           - pipeline CSR write (passed through when idle)
//   mstatus_in/mtvec_in/mepc_in - current CSR values from the CSR file
//   csr_we/addr_write/wdata/is_csrrc - write port into the CSR file
//   busy                 - pipeline stall while sequencing
//   redirect_valid/pc    - one-cycle PC redirect
//   priv_mode            - current privilege (3 = M, 0 = U)
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic [XLEN-1:0]   trap_cause,
    input  logic [XLEN-1:0]   trap_tval,
    input  logic              mret_req,
    input  logic              pipe_csr_we,
    input  logic [CSR_AW-1:0] pipe_csr_addr,
    input  logic [XLEN-1:0]   pipe_csr_wdata,
    input  logic              pipe_is_csrrc,
    input  logic [XLEN-1:0]   mstatus_in,
    input  logic [XLEN-1:0]   mtvec_in,
    input  logic [XLEN-1:0]   mepc_in,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_addr_write,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_is_csrrc,
    output logic              busy,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [1:0]        priv_mode
);

    localparam logic [CSR_AW-1:0] c_ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] c_ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] c_ADDR_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] c_ADDR_MTVAL   = CSR_AW'(12'h343);
    localparam logic [1:0]        c_PRIV_M       = 2'd3;
    localparam logic [XLEN-1:0]   c_MASK_BIT0    = ~(XLEN'(1));
    localparam logic [XLEN-1:0]   c_MASK_BITS10  = ~(XLEN'(3));
    localparam logic [XLEN-1:0]   c_MASK_MSB     = ~(XLEN'(1) << (XLEN-1));

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_T_EPC    = 3'd1,
        S_T_CAUSE  = 3'd2,
        S_T_TVAL   = 3'd3,
        S_T_STATUS = 3'd4,
        S_M_STATUS = 3'd5,
        S_REDIR    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_cause;
    logic [XLEN-1:0]   r_tval;
    logic              r_is_mret;
    logic [1:0]        r_priv;

    logic [XLEN-1:0]   w_trap_status;
    logic [XLEN-1:0]   w_mret_status;
    logic [XLEN-1:0]   w_vec_base;
    logic [XLEN-1:0]   w_vec_off;
    logic [XLEN-1:0]   w_trap_target;

    assign priv_mode = r_priv;

    // mstatus rewrite on trap entry: stack MIE into MPIE, disable MIE,
    // record the privilege we trapped from in MPP.
    always_comb begin
        w_trap_status        = mstatus_in;
        w_trap_status[7]     = mstatus_in[3];
        w_trap_status[3]     = 1'b0;
        w_trap_status[12:11] = r_priv;
    end

    // mstatus rewrite on mret: restore MIE from MPIE, set MPIE, clear MPP.
    always_comb begin
        w_mret_status        = mstatus_in;
        w_mret_status[3]     = mstatus_in[7];
        w_mret_status[7]     = 1'b1;
        w_mret_status[12:11] = 2'b00;
    end

    // Vectored mode applies to interrupts only; the offset is 4 * cause
    // code (interrupt flag stripped), wrapping at XLEN bits.
    assign w_vec_base = mtvec_in & c_MASK_BITS10;
    assign w_vec_off  = (r_cause & c_MASK_MSB) << 2;
    assign w_trap_target = (mtvec_in[1:0] == 2'b01 && r_cause[XLEN-1])
                         ? (w_vec_base + w_vec_off) : w_vec_base;

    // State and payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cause   <= '0;
            r_tval    <= '0;
            r_is_mret <= 1'b0;
            r_priv    <= c_PRIV_M;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE) begin
                if (trap_req) begin
                    r_pc      <= trap_pc & c_MASK_BIT0;
                    r_cause   <= trap_cause;
                    r_tval    <= trap_tval;
                    r_is_mret <= 1'b0;
                end else if (mret_req) begin
                    r_is_mret <= 1'b1;
                end
            end
            if (r_state == S_T_STATUS) begin
                r_priv <= c_PRIV_M;
            end else if (r_state == S_M_STATUS) begin
                r_priv <= mstatus_in[12:11];
            end
        end
    end

    // Next state and port outputs. Outputs are held at zero while reset is
    // asserted so an in-flight sequence cannot issue one more write.
    always_comb begin
        w_next_state   = r_state;
        csr_we         = 1'b0;
        csr_addr_write = '0;
        csr_wdata      = '0;
        csr_is_csrrc   = 1'b0;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    csr_we         = pipe_csr_we;
                    csr_addr_write = pipe_csr_addr;
                    csr_wdata      = pipe_csr_wdata;
                    csr_is_csrrc   = pipe_is_csrrc;
                    if (trap_req) begin
                        csr_we       = 1'b0;
                        w_next_state = S_T_EPC;
                    end else if (mret_req) begin
                        csr_we       = 1'b0;
                        w_next_state = S_M_STATUS;
                    end
                end
                S_T_EPC: begin
                    busy           = 1'b1;
                    csr_we         = 1'b1;
                    csr_addr_write = c_ADDR_MEPC;
                    csr_wdata      = r_pc;
                    w_next_state   = S_T_CAUSE;
                end
                S_T_CAUSE: begin
                    busy           = 1'b1;
                    csr_we         = 1'b1;
                    csr_addr_write = c_ADDR_MCAUSE;
                    csr_wdata      = r_cause;
                    w_next_state   = S_T_TVAL;
                end
                S_T_TVAL: begin
                    busy           = 1'b1;
                    csr_we         = 1'b1;
                    csr_addr_write = c_ADDR_MTVAL;
                    csr_wdata      = r_tval;
                    w_next_state   = S_T_STATUS;
                end
                S_T_STATUS: begin
                    busy           = 1'b1;
                    csr_we         = 1'b1;
                    csr_addr_write = c_ADDR_MSTATUS;
                    csr_wdata      = w_trap_status;
                    w_next_state   = S_REDIR;
                end
                S_M_STATUS: begin
                    busy           = 1'b1;
                    csr_we         = 1'b1;
                    csr_addr_write = c_ADDR_MSTATUS;
                    csr_wdata      = w_mret_status;
                    w_next_state   = S_REDIR;
                end
                S_REDIR: begin
                    busy           = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = r_is_mret ? (mepc_in & c_MASK_BIT0)
                                               : w_trap_target;
                    w_next_state   = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_ctrl
// Purpose  : Directed self-checking bench for csr_trap_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;

    logic        clk;
    logic        reset;
    logic        trap_req;
    logic [63:0] trap_pc;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic        mret_req;
    logic        pipe_csr_we;
    logic [11:0] pipe_csr_addr;
    logic [63:0] pipe_csr_wdata;
    logic        pipe_is_csrrc;
    logic [63:0] mstatus_in;
    logic [63:0] mtvec_in;
    logic [63:0] mepc_in;
    logic        csr_we;
    logic [11:0] csr_addr_write;
    logic [63:0] csr_wdata;
    logic        csr_is_csrrc;
    logic        busy;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  priv_mode;

    int checks = 0;
    int errors = 0;

    csr_trap_ctrl #(.XLEN(64), .CSR_AW(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .trap_req       (trap_req),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .trap_tval      (trap_tval),
        .mret_req       (mret_req),
        .pipe_csr_we    (pipe_csr_we),
        .pipe_csr_addr  (pipe_csr_addr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_is_csrrc  (pipe_is_csrrc),
        .mstatus_in     (mstatus_in),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .csr_we         (csr_we),
        .csr_addr_write (csr_addr_write),
        .csr_wdata      (csr_wdata),
        .csr_is_csrrc   (csr_is_csrrc),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .priv_mode      (priv_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect an internally generated CSR write in the current cycle.
    task automatic expect_write(input string tag, input logic [11:0] addr, input logic [63:0] data);
        #1;
        check({tag, ".busy"},  64'(busy), 64'd1);
        check({tag, ".we"},    64'(csr_we), 64'd1);
        check({tag, ".addr"},  64'(csr_addr_write), 64'(addr));
        check({tag, ".data"},  csr_wdata, data);
        check({tag, ".rrc"},   64'(csr_is_csrrc), 64'd0);
        check({tag, ".rv"},    64'(redirect_valid), 64'd0);
    endtask

    task automatic expect_redirect(input string tag, input logic [63:0] pc);
        #1;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        check({tag, ".we"},   64'(csr_we), 64'd0);
        check({tag, ".rv"},   64'(redirect_valid), 64'd1);
        check({tag, ".pc"},   redirect_pc, pc);
    endtask

    task automatic expect_idle(input string tag, input logic [1:0] priv);
        #1;
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".rv"},   64'(redirect_valid), 64'd0);
        check({tag, ".priv"}, 64'(priv_mode), 64'(priv));
    endtask

    initial begin
        reset = 1'b1; trap_req = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0;
        mret_req = 1'b0; pipe_csr_we = 1'b0; pipe_csr_addr = '0; pipe_csr_wdata = '0;
        pipe_is_csrrc = 1'b0; mstatus_in = '0; mtvec_in = '0; mepc_in = '0;
        tick();
        tick();
        #1;
        check("rst.priv", 64'(priv_mode), 64'd3);
        check("rst.we",   64'(csr_we), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.addr", 64'(csr_addr_write), 64'd0);

        // Pipeline pass-through in IDLE
        tick();
        reset = 1'b0;
        pipe_csr_we = 1'b1; pipe_csr_addr = 12'h340; pipe_csr_wdata = 64'hAB; pipe_is_csrrc = 1'b1;
        #1;
        check("pass.we",   64'(csr_we), 64'd1);
        check("pass.addr", 64'(csr_addr_write), 64'h340);
        check("pass.data", csr_wdata, 64'hAB);
        check("pass.rrc",  64'(csr_is_csrrc), 64'd1);
        check("pass.busy", 64'(busy), 64'd0);
        pipe_is_csrrc = 1'b0;

        // Synchronous exception from M mode; same-cycle pipe write dropped
        tick();
        trap_req = 1'b1; trap_pc = 64'h80000105; trap_cause = 64'd2; trap_tval = 64'hDEAD;
        mstatus_in = 64'h8; mtvec_in = 64'h80001000;
        #1;
        check("t0.we",   64'(csr_we), 64'd0);
        check("t0.busy", 64'(busy), 64'd0);
        tick();
        trap_req = 1'b0; pipe_csr_we = 1'b0;
        expect_write("t1", 12'h341, 64'h80000104);
        tick(); expect_write("t2", 12'h342, 64'd2);
        tick(); expect_write("t3", 12'h343, 64'hDEAD);
        tick(); expect_write("t4", 12'h300, 64'h1880);
        tick(); expect_redirect("t5", 64'h80001000);
        tick(); expect_idle("t6", 2'd3);

        // Vectored interrupt with trap, mret and pipe write in the same cycle;
        // requests held during busy must be ignored.
        trap_req = 1'b1; mret_req = 1'b1; pipe_csr_we = 1'b1;
        trap_pc = 64'h200; trap_cause = 64'h8000000000000007; trap_tval = 64'h0;
        mstatus_in = 64'h0; mtvec_in = 64'h80001001;
        #1;
        check("v0.we", 64'(csr_we), 64'd0);
        tick(); expect_write("v1", 12'h341, 64'h200);
        tick(); expect_write("v2", 12'h342, 64'h8000000000000007);
        tick(); expect_write("v3", 12'h343, 64'h0);
        tick(); expect_write("v4", 12'h300, 64'h1800);
        tick();
        trap_req = 1'b0; mret_req = 1'b0; pipe_csr_we = 1'b0;
        expect_redirect("v5", 64'h8000101C);
        tick(); expect_idle("v6", 2'd3);

        // mret back to M
        mret_req = 1'b1; mstatus_in = 64'h1880; mepc_in = 64'h80000104;
        #1;
        check("m0.we", 64'(csr_we), 64'd0);
        tick();
        mret_req = 1'b0;
        expect_write("m1", 12'h300, 64'h88);
        tick(); expect_redirect("m2", 64'h80000104);
        check("m2.priv", 64'(priv_mode), 64'd3);
        tick(); expect_idle("m3", 2'd3);

        // mret to U mode, odd mepc
        mret_req = 1'b1; mstatus_in = 64'h80; mepc_in = 64'h1235;
        tick();
        mret_req = 1'b0;
        expect_write("u1", 12'h300, 64'h88);
        tick(); expect_redirect("u2", 64'h1234);
        check("u2.priv", 64'(priv_mode), 64'd0);
        tick(); expect_idle("u3", 2'd0);

        // Trap taken from U mode: MPP records 0, priv returns to 3
        trap_req = 1'b1; trap_pc = 64'h1234; trap_cause = 64'd8; trap_tval = 64'h0;
        mstatus_in = 64'h8; mtvec_in = 64'h00000501;
        tick();
        trap_req = 1'b0;
        expect_write("x1", 12'h341, 64'h1234);
        tick(); expect_write("x2", 12'h342, 64'd8);
        tick(); expect_write("x3", 12'h343, 64'h0);
        tick(); expect_write("x4", 12'h300, 64'h80);
        check("x4.priv", 64'(priv_mode), 64'd0);
        tick(); expect_redirect("x5", 64'h500);
        check("x5.priv", 64'(priv_mode), 64'd3);
        tick(); expect_idle("x6", 2'd3);

        // Drop to U, then reset in the middle of a trap
        mret_req = 1'b1; mstatus_in = 64'h0; mepc_in = 64'h4000;
        tick();
        mret_req = 1'b0;
        tick();
        tick(); expect_idle("r0", 2'd0);
        trap_req = 1'b1; trap_pc = 64'h4000; trap_cause = 64'd2; trap_tval = 64'h1;
        tick();
        trap_req = 1'b0;
        expect_write("r1", 12'h341, 64'h4000);
        tick();
        reset = 1'b1;
        #1;
        check("r2.we", 64'(csr_we), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("r3.we", 64'(csr_we), 64'd0);
        expect_idle("r3", 2'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check("r4.rv", 64'(redirect_valid), 64'd0);
            check("r4.we", 64'(csr_we), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
